mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port memory between an instruction-fetch requester and
//   a data (load/store) requester. At most one transaction is in flight.
//   Data normally wins arbitration. A starvation counter guarantees the fetch
//   side a grant after STARVE_MAX consecutive data grants made while fetch
//   was waiting. Sub-word stores are lane-replicated with byte enables.
//   Sub-word loads are lane-selected and zero/sign-extended. Misaligned data
//   accesses are answered with an error and never reach memory.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN):
//   When defined, a wait counter aborts a memory access that has not been
//   acknowledged after TIMEOUT cycles. The served requester then gets err=1
//   and rdata=0. When undefined, the arbiter waits for ack indefinitely and
//   if_err_o is tied to 0.
//
// Parameters:
//   STARVE_MAX  consecutive data grants allowed while a fetch is pending
//   TIMEOUT     ack-wait limit in cycles (only with MEM_ARB_TIMEOUT_EN)
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   if_req_i/addr_i    fetch request (held until if_valid_o), word address
//   if_valid_o/err_o   one-cycle fetch response pulse and error flag
//   if_rdata_o         fetched word
//   d_req_i            data request (held until d_valid_o)
//   d_we_i             1 = store
//   d_acc_i            access size: 0 byte, 1 half, 2/3 word
//   d_sext_i           sign-extend sub-word loads
//   d_addr_i           byte address
//   d_wdata_i          right-aligned store data
//   d_valid_o/err_o    one-cycle data response pulse and error flag
//   d_rdata_o          extended load data (0 for stores and errors)
//   mem_req_o          memory request, held until mem_ack_i
//   mem_we_o           memory write
//   mem_addr_o         word address ([1:0] always 0)
//   mem_be_o           byte enables
//   mem_wdata_o        lane-replicated write data
//   mem_ack_i          transfer done; mem_rdata_i valid in the same cycle
//   mem_rdata_i        read word
//
// Handshake: a requester raises req with stable fields and keeps it high
// until it sees its valid pulse; it drops req on the clock edge that ends
// the response cycle. Requests are sampled only while the arbiter is idle.
// On the memory side, mem_req_o and its fields stay stable until the cycle
// in which mem_ack_i is seen high.
// -----------------------------------------------------------------------------

`default_nettype none

module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_valid_o,
  output logic        if_err_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [1:0]  d_acc_i,
  input  logic        d_sext_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_valid_o,
  output logic        d_err_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  // The counter must be able to hold STARVE_MAX itself.
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  state_e        state_q;
  logic [SW-1:0] starve_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;

  logic        if_valid_q;
  logic [31:0] if_rdata_q;
  logic        d_valid_q;
  logic        d_err_q;
  logic [31:0] d_rdata_q;

  // Latched data-request fields needed to shape the load result.
  logic        d_we_q;
  logic [1:0]  d_acc_q;
  logic        d_sext_q;
  logic [1:0]  d_off_q;

`ifdef MEM_ARB_TIMEOUT_EN
  // Wait counter runs from 0 to TIMEOUT-1 while in BUSY_x.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  logic [TW-1:0] wait_q;
  logic          if_err_q;
`else
  // TIMEOUT only matters when the timeout feature is built in.
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
`endif

  // Fetch addresses are word aligned; the low bits carry no information.
  logic unused_if_addr_lsb;
  assign unused_if_addr_lsb = ^if_addr_i[1:0];

  // ---------------------------------------------------------------------------
  // Arbitration: data first, except when fetch has been passed over
  // STARVE_MAX times in a row.
  // ---------------------------------------------------------------------------
  logic take_f_c;
  logic take_d_c;

  always_comb begin
    take_f_c = if_req_i && (!d_req_i || (starve_q == STARVE_LIM));
    take_d_c = d_req_i && !take_f_c;
  end

  // ---------------------------------------------------------------------------
  // Data request decode: byte enables, lane replication, alignment check.
  // ---------------------------------------------------------------------------
  logic [3:0]  d_be_c;
  logic [31:0] d_wdata_c;
  logic        d_misal_c;

  always_comb begin
    d_be_c    = 4'b1111;
    d_wdata_c = d_wdata_i;
    d_misal_c = 1'b0;
    case (d_acc_i)
      2'd0: begin
        d_be_c    = 4'b0001 << d_addr_i[1:0];
        d_wdata_c = {4{d_wdata_i[7:0]}};
      end
      2'd1: begin
        d_be_c    = 4'b0011 << d_addr_i[1:0];
        d_wdata_c = {2{d_wdata_i[15:0]}};
        d_misal_c = d_addr_i[0];
      end
      default: begin
        // Size 3 is handled exactly like a word access.
        d_misal_c = |d_addr_i[1:0];
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load result shaping from the word returned by memory.
  // ---------------------------------------------------------------------------
  logic [31:0] ld_shift_c;
  logic [31:0] ld_data_c;

  always_comb begin
    ld_shift_c = mem_rdata_i >> {d_off_q, 3'b000};
    case (d_acc_q)
      2'd0:    ld_data_c = {{24{d_sext_q & ld_shift_c[7]}},  ld_shift_c[7:0]};
      2'd1:    ld_data_c = {{16{d_sext_q & ld_shift_c[15]}}, ld_shift_c[15:0]};
      default: ld_data_c = mem_rdata_i;
    endcase
    if (d_we_q) begin
      ld_data_c = 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Main FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= 32'h0;
      d_we_q      <= 1'b0;
      d_acc_q     <= 2'd0;
      d_sext_q    <= 1'b0;
      d_off_q     <= 2'd0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_q      <= '0;
      if_err_q    <= 1'b0;
`endif
    end else begin
      // Response outputs are only non-zero during the single RESP cycle.
      if_valid_q <= 1'b0;
      if_rdata_q <= 32'h0;
      d_valid_q  <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
      if_err_q   <= 1'b0;
`endif

      case (state_q)
        IDLE: begin
          if (take_f_c) begin
            state_q     <= BUSY_F;
            starve_q    <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {if_addr_i[31:2], 2'b00};
            mem_be_q    <= 4'b1111;
            mem_wdata_q <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_q      <= '0;
`endif
          end else if (take_d_c) begin
            // Only grants that overtake a waiting fetch count as starvation.
            if (if_req_i && (starve_q != STARVE_LIM)) begin
              starve_q <= starve_q + 1'b1;
            end
            d_we_q   <= d_we_i;
            d_acc_q  <= d_acc_i;
            d_sext_q <= d_sext_i;
            d_off_q  <= d_addr_i[1:0];
            if (d_misal_c) begin
              // Answer directly; memory is never touched.
              state_q   <= RESP;
              d_valid_q <= 1'b1;
              d_err_q   <= 1'b1;
            end else begin
              state_q     <= BUSY_D;
              mem_req_q   <= 1'b1;
              mem_we_q    <= d_we_i;
              mem_addr_q  <= {d_addr_i[31:2], 2'b00};
              mem_be_q    <= d_be_c;
              mem_wdata_q <= d_wdata_c;
`ifdef MEM_ARB_TIMEOUT_EN
              wait_q      <= '0;
`endif
            end
          end
        end

        BUSY_F: begin
          if (mem_ack_i) begin
            state_q    <= RESP;
            mem_req_q  <= 1'b0;
            if_valid_q <= 1'b1;
            if_rdata_q <= mem_rdata_i;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            state_q    <= RESP;
            mem_req_q  <= 1'b0;
            if_valid_q <= 1'b1;
            if_err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end

        BUSY_D: begin
          if (mem_ack_i) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            d_valid_q <= 1'b1;
            d_rdata_q <= ld_data_c;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            d_valid_q <= 1'b1;
            d_err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_valid_o   = d_valid_q;
  assign d_err_o     = d_err_q;
  assign d_rdata_o   = d_rdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign if_err_o    = if_err_q;
`else
  assign if_err_o    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed self-checking bench for mem_arbiter (STARVE_MAX=4, TIMEOUT=8).
// Each scenario task drives requests and the memory acknowledge by hand and
// compares the DUT outputs against hand-computed values one step after the
// clock edge. With MEM_ARB_TIMEOUT_EN defined the timeout path is exercised;
// otherwise the bench confirms the arbiter keeps waiting for ack.
// -----------------------------------------------------------------------------

`timescale 1ns/1ps

module tb_mem_arbiter;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'h0;
  logic        if_valid_o;
  logic        if_err_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [1:0]  d_acc_i = 2'd0;
  logic        d_sext_i = 1'b0;
  logic [31:0] d_addr_i = 32'h0;
  logic [31:0] d_wdata_i = 32'h0;
  logic        d_valid_o;
  logic        d_err_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .STARVE_MAX(4),
    .TIMEOUT   (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_valid_o (if_valid_o),
    .if_err_o   (if_err_o),
    .if_rdata_o (if_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_acc_i    (d_acc_i),
    .d_sext_i   (d_sext_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_valid_o  (d_valid_o),
    .d_err_o    (d_err_o),
    .d_rdata_o  (d_rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_be_o   (mem_be_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = 32'h0;
    d_req_i     = 1'b0;
    d_we_i      = 1'b0;
    d_acc_i     = 2'd0;
    d_sext_i    = 1'b0;
    d_addr_i    = 32'h0;
    d_wdata_i   = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic drive_data(input logic we, input logic [1:0] acc, input logic sext,
                            input logic [31:0] addr, input logic [31:0] wdata);
    d_req_i   = 1'b1;
    d_we_i    = we;
    d_acc_i   = acc;
    d_sext_i  = sext;
    d_addr_i  = addr;
    d_wdata_i = wdata;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive_data(1'b1, 2'd2, 1'b0, 32'h44, 32'h1234_5678);
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_mem_ctl: got %b expected 000000", {mem_req_o, mem_we_o, mem_be_o});
    end
    n_cmp++;
    if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", mem_addr_o, mem_wdata_o);
    end
    n_cmp++;
    if ({if_valid_o, if_err_o, d_valid_o, d_err_o} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_resp_flags: got %b expected 0000", {if_valid_o, if_err_o, d_valid_o, d_err_o});
    end
    n_cmp++;
    if (if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rdata: got if %h d %h expected 0", if_rdata_o, d_rdata_o);
    end
    // Requests held during reset must not be granted while reset is high.
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold_no_grant: got %b expected 0", mem_req_o);
    end
    apply_reset();
  endtask

  task automatic test_priority();
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    drive_data(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    tick();  // grant: data wins
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_we_o !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_data_first: got req %b addr %h we %b expected 1 00000200 0",
               mem_req_o, mem_addr_o, mem_we_o);
    end
    n_cmp++;
    if (mem_be_o !== 4'b1111) begin
      n_bad++;
      $display("FAIL prio_data_be: got %b expected 1111", mem_be_o);
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    tick();  // RESP
    n_cmp++;
    if (d_valid_o !== 1'b1 || d_rdata_o !== 32'hDEAD_BEEF || d_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_data_resp: got valid %b rdata %h err %b expected 1 deadbeef 0",
               d_valid_o, d_rdata_o, d_err_o);
    end
    n_cmp++;
    if (if_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_resp_other: got if_valid %b mem_req %b expected 0 0", if_valid_o, mem_req_o);
    end
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    d_req_i     = 1'b0;
    tick();  // back to IDLE
    n_cmp++;
    if (d_valid_o !== 1'b0 || d_rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_idle_gap: got valid %b rdata %h req %b expected 0 0 0",
               d_valid_o, d_rdata_o, mem_req_o);
    end
    tick();  // fetch granted
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_be_o !== 4'b1111 || mem_we_o !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_fetch_grant: got req %b addr %h be %b we %b expected 1 00000100 1111 0",
               mem_req_o, mem_addr_o, mem_be_o, mem_we_o);
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    tick();
    n_cmp++;
    if (if_valid_o !== 1'b1 || if_rdata_o !== 32'h1234_5678 || if_err_o !== 1'b0 || d_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_fetch_resp: got valid %b rdata %h err %b d_valid %b expected 1 12345678 0 0",
               if_valid_o, if_rdata_o, if_err_o, d_valid_o);
    end
    mem_ack_i = 1'b0;
    if_req_i  = 1'b0;
    tick();
    apply_reset();
  endtask

  task automatic test_starvation();
    logic [5:0] exp_fetch;
    int         d_served;
    logic       got_f;
    exp_fetch = 6'b010000;  // grant order D,D,D,D,F,D
    d_served  = 0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    drive_data(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();  // grant
      got_f = (mem_addr_o === 32'h100);
      n_cmp++;
      if (mem_req_o !== 1'b1 || got_f !== exp_fetch[i]) begin
        n_bad++;
        $display("FAIL starve_grant_%0d: got req %b fetch %b expected 1 %b", i, mem_req_o, got_f, exp_fetch[i]);
      end
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h0;
      tick();  // RESP
      n_cmp++;
      if ({if_valid_o, d_valid_o} !== (exp_fetch[i] ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL starve_resp_%0d: got if/d valid %b expected %b", i,
                 {if_valid_o, d_valid_o}, (exp_fetch[i] ? 2'b10 : 2'b01));
      end
      mem_ack_i = 1'b0;
      if (!exp_fetch[i]) begin
        d_served++;
        if (d_served == 5) d_req_i = 1'b0;
      end
      tick();  // back to IDLE
    end
    if_req_i = 1'b0;
    apply_reset();
  endtask

  task automatic test_store_byte();
    drive_data(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5);
    tick();
    n_cmp++;
    if (mem_addr_o !== 32'h1000 || mem_be_o !== 4'b1000) begin
      n_bad++;
      $display("FAIL store_byte_addr_be: got %h %b expected 00001000 1000", mem_addr_o, mem_be_o);
    end
    n_cmp++;
    if (mem_wdata_o !== 32'hA5A5_A5A5 || mem_we_o !== 1'b1) begin
      n_bad++;
      $display("FAIL store_byte_data: got %h we %b expected a5a5a5a5 1", mem_wdata_o, mem_we_o);
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    n_cmp++;
    if (d_valid_o !== 1'b1 || d_rdata_o !== 32'h0 || d_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL store_byte_resp: got valid %b rdata %h err %b expected 1 0 0", d_valid_o, d_rdata_o, d_err_o);
    end
    mem_ack_i = 1'b0;
    d_req_i   = 1'b0;
    tick();
    // Half store at offset 2: upper two lanes, half replicated.
    drive_data(1'b1, 2'd1, 1'b0, 32'h1006, 32'hFFFF_BEEF);
    tick();
    n_cmp++;
    if (mem_addr_o !== 32'h1004 || mem_be_o !== 4'b1100 || mem_wdata_o !== 32'hBEEF_BEEF) begin
      n_bad++;
      $display("FAIL store_half: got %h %b %h expected 00001004 1100 beefbeef", mem_addr_o, mem_be_o, mem_wdata_o);
    end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    d_req_i   = 1'b0;
    tick();
  endtask

  task automatic test_load_ext();
    logic [31:0] exp_v [4];
    logic [1:0]  acc_v [4];
    logic        sx_v  [4];
    logic [31:0] ad_v  [4];
    exp_v = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80, 32'h0000_0080};
    acc_v = '{2'd1, 2'd1, 2'd0, 2'd0};
    sx_v  = '{1'b1, 1'b0, 1'b1, 1'b0};
    ad_v  = '{32'h2002, 32'h2002, 32'h2003, 32'h2003};
    for (int i = 0; i < 4; i++) begin
      drive_data(1'b0, acc_v[i], sx_v[i], ad_v[i], 32'h0);
      tick();
      n_cmp++;
      if (mem_addr_o !== 32'h2000 || mem_we_o !== 1'b0) begin
        n_bad++;
        $display("FAIL load_req_%0d: got addr %h we %b expected 00002000 0", i, mem_addr_o, mem_we_o);
      end
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h8001_0000;
      tick();
      n_cmp++;
      if (d_valid_o !== 1'b1 || d_rdata_o !== exp_v[i]) begin
        n_bad++;
        $display("FAIL load_ext_%0d: got valid %b rdata %h expected 1 %h", i, d_valid_o, d_rdata_o, exp_v[i]);
      end
      mem_ack_i = 1'b0;
      d_req_i   = 1'b0;
      tick();
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  acc_v [3];
    logic [31:0] ad_v  [3];
    acc_v = '{2'd2, 2'd1, 2'd3};
    ad_v  = '{32'h3001, 32'h3003, 32'h3002};
    for (int i = 0; i < 3; i++) begin
      drive_data(1'b0, acc_v[i], 1'b0, ad_v[i], 32'h0);
      mem_ack_i = 1'b1;  // must be ignored outside BUSY_x
      tick();
      n_cmp++;
      if (d_valid_o !== 1'b1 || d_err_o !== 1'b1 || mem_req_o !== 1'b0 || d_rdata_o !== 32'h0) begin
        n_bad++;
        $display("FAIL misal_resp_%0d: got valid %b err %b req %b rdata %h expected 1 1 0 0",
                 i, d_valid_o, d_err_o, mem_req_o, d_rdata_o);
      end
      d_req_i = 1'b0;
      tick();
      n_cmp++;
      if (d_valid_o !== 1'b0 || d_err_o !== 1'b0 || mem_req_o !== 1'b0) begin
        n_bad++;
        $display("FAIL misal_after_%0d: got valid %b err %b req %b expected 0 0 0", i, d_valid_o, d_err_o, mem_req_o);
      end
      mem_ack_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    drive_data(1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_busy: got %b expected 1", mem_req_o);
    end
    #2;
    rst_i   = 1'b1;
    d_req_i = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_req_drop: got %b expected 0", mem_req_o);
    end
    mem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (d_valid_o !== 1'b0 || if_valid_o !== 1'b0) pulses++;
      if (i == 1) rst_i = 1'b0;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", pulses);
    end
    mem_ack_i = 1'b0;
    apply_reset();
  endtask

  task automatic test_ack_wait();
    drive_data(1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
    tick();  // grant
    repeat (7) tick();
`ifdef MEM_ARB_TIMEOUT_EN
    n_cmp++;
    if (mem_req_o !== 1'b1 || d_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_early: got req %b valid %b expected 1 0", mem_req_o, d_valid_o);
    end
    tick();  // eighth wait cycle expires
    n_cmp++;
    if (d_valid_o !== 1'b1 || d_err_o !== 1'b1 || d_rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_resp: got valid %b err %b rdata %h req %b expected 1 1 0 0",
               d_valid_o, d_err_o, d_rdata_o, mem_req_o);
    end
    d_req_i = 1'b0;
    tick();
`else
    repeat (13) tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || d_valid_o !== 1'b0 || if_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_forever: got req %b valid %b if_err %b expected 1 0 0", mem_req_o, d_valid_o, if_err_o);
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    tick();
    n_cmp++;
    if (d_valid_o !== 1'b1 || d_err_o !== 1'b0 || d_rdata_o !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL wait_late_ack: got valid %b err %b rdata %h expected 1 0 cafef00d", d_valid_o, d_err_o, d_rdata_o);
    end
    mem_ack_i = 1'b0;
    d_req_i   = 1'b0;
    tick();
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    #3;
    test_reset();
    test_priority();
    test_starvation();
    test_store_byte();
    test_load_ext();
    test_misaligned();
    test_reset_mid();
    test_ack_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
